// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider.
// Holds the default operand width and the controller state enumeration.
package divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_stage.sv
// Trial-subtract stage of the restoring divider.
// Ports:
//   a_i      - minuend (WIDTH bits)
//   b_i      - subtrahend (WIDTH bits)
//   diff_o   - a_i - b_i modulo 2**WIDTH
//   borrow_o - 1 when b_i > a_i (the result is negative)
module sub_stage #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH:0] sum;

  // Two's-complement subtract; the carry out is the inverted borrow.
  assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
  assign diff_o   = sum[WIDTH-1:0];
  assign borrow_o = ~sum[WIDTH];

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional feature macro: DIVIDER_SEQ_LED_EN adds the in_led operand mirror.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start               - request a divide, sampled only while idle
//   a, b                - unsigned dividend and divisor
//   quotient, remainder - registered results, updated when an operation completes
//   busy                - high while quotient bits are being produced
//   done                - one-cycle completion pulse
//   div_by_zero         - set when the completed operation had b == 0
//   in_led              - {latched b, latched a} (DIVIDER_SEQ_LED_EN only)
module divider_seq
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
`ifdef DIVIDER_SEQ_LED_EN
  ,
  output logic [2*WIDTH-1:0] in_led
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   quo_q;        // dividend bits shifted out, quotient bits shifted in
  logic [WIDTH:0]     rem_q;        // partial remainder
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic [WIDTH:0]     shift_d;
  logic [WIDTH:0]     diff_d;
  logic               borrow_d;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               unused_rem_msb;

  // Partial remainder shifted left with the next dividend bit.
  assign shift_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  sub_stage #(
    .WIDTH(WIDTH + 1)
  ) u_sub_stage (
    .a_i     (shift_d),
    .b_i     ({1'b0, b_q}),
    .diff_o  (diff_d),
    .borrow_o(borrow_d)
  );

  // Restore on a negative trial result; the quotient bit is the inverted borrow.
  assign rem_d = borrow_d ? shift_d : diff_d;
  assign quo_d = WIDTH'({quo_q, ~borrow_d});

  // The restored remainder is always below b, so its top bit never feeds back.
  assign unused_rem_msb = rem_q[WIDTH];

  // Controller, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      // Status is registered from the current state, so it trails the state by one cycle.
      busy_q <= (state_q == RUN);
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            quo_q   <= a;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            state_q <= (b == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (b_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= a_q;
            dbz_q       <= 1'b1;
          end else begin
            quotient_q  <= quo_q;
            remainder_q <= rem_q[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

`ifdef DIVIDER_SEQ_LED_EN
  assign in_led = {b_q, a_q};
`endif

endmodule

// File: tb/tb_divider_seq.sv
// Randomized and directed bench for divider_seq with a queue-based scoreboard.
module tb_divider_seq;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
`ifdef DIVIDER_SEQ_LED_EN
  logic [7:0] in_led;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  divider_seq #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
`ifdef DIVIDER_SEQ_LED_EN
    ,
    .in_led     (in_led)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: plain integer division, saturated quotient for a zero divisor.
  function automatic exp_t model(input int av, input int bv);
    exp_t e;
    if (bv == 0) begin
      e.q = 4'hF;
      e.r = 4'(av);
      e.z = 1'b1;
    end else begin
      e.q = 4'(av / bv);
      e.r = 4'(av % bv);
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.z));
      end
    end
  end

  // Call at #1 after a rising edge with the DUT idle; returns in the done cycle.
  task automatic do_op(input int av, input int bv, input bit midrun);
    int  bcnt;
    int  lat;
    int  extra;
    bit  seen;
    start = 1'b1;
    a     = 4'(av);
    b     = 4'(bv);
    exp_q.push_back(model(av, bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("dbz_clear_on_start", int'(div_by_zero), 0);
`ifdef DIVIDER_SEQ_LED_EN
    chk("in_led", int'(in_led), (bv << 4) | av);
`endif
    bcnt = 0;
    lat  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (midrun && n == 1) begin
        start = 1'b1;
        a     = 4'(av ^ 15);
        b     = (bv == 1) ? 4'd2 : 4'd1;
      end
      if (midrun && n == 2) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done for a=%0d b=%0d", av, bv);
    end else begin
      chk("latency", lat, (bv == 0) ? 1 : 5);
      chk("busy_cycles", bcnt, (bv == 0) ? 0 : 4);
    end
    if (midrun) begin
      extra = 0;
      for (int n = 0; n < 8; n++) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      chk("single_done", extra, 0);
    end
  endtask

  initial begin
    int dones;
    int last_t;
    int extra;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
`ifdef DIVIDER_SEQ_LED_EN
    chk("rst_in_led", int'(in_led), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, including zero divisor and its clearing.
    do_op(13, 3, 1'b0);
    do_op(9, 0, 1'b0);
    do_op(7, 2, 1'b0);
    do_op(0, 5, 1'b0);
    do_op(11, 3, 1'b1);

    // Exhaustive sweep over non-zero divisors.
    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 16; y++)
        do_op(x, y, 1'b0);

    // Random operands, zero divisor allowed.
    for (int i = 0; i < 40; i++)
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 4'd11;
    b     = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);

    // Start held high: back-to-back operations every six cycles.
    for (int i = 0; i < 4; i++) exp_q.push_back(model(15, 1));
    start  = 1'b1;
    a      = 4'd15;
    b      = 4'd1;
    dones  = 0;
    last_t = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (dones == 0) chk("held_first_latency", n, 5);
        else chk("held_period", n - last_t, 6);
        last_t = n;
        dones++;
        if (dones == 4) begin
          start = 1'b0;
          break;
        end
      end
    end
    chk("held_done_count", dones, 4);
    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
